// File: rtl/philv_ctrl_pkg.sv
// rtl/philv_ctrl_pkg.sv - shared state, opcode and ALU source encodings for the PhilosophyV controller
package philv_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_EXEC_R    = 4'd2,
      ST_EXEC_I    = 4'd3,
      ST_ADDR      = 4'd4,
      ST_MEM_LD    = 4'd5,
      ST_MEM_ST    = 4'd6,
      ST_EXEC_B    = 4'd7,
      ST_WRITEBACK = 4'd8,
      ST_TRAP      = 4'd9
   } state_t;

   localparam logic [6:0] OPCODE_ALU_REG = 7'b0110011;
   localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;

   localparam logic ALU_SRC_A_PC     = 1'b0;
   localparam logic ALU_SRC_A_REGOUT = 1'b1;

   localparam logic [1:0] ALU_SRC_B_REGOUT = 2'd0;
   localparam logic [1:0] ALU_SRC_B_CONST4 = 2'd1;
   localparam logic [1:0] ALU_SRC_B_IMMED  = 2'd2;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - retired-instruction counter, wraps modulo 2^CNT_WIDTH
module retire_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle control FSM; PHILV_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module multicycle_controller
   import philv_ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH    = 7,
   parameter int ALU_SRC_B_WIDTH = 2,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [OPCODE_WIDTH-1:0]    opCode,
   input  logic                       memReady,
   input  logic                       branchTaken,
   output logic                       PCWrite,
   output logic                       PCBranch,
   output logic                       IRWrite,
   output logic                       regFileWrite,
   output logic                       ALUOverride,
   output logic                       ALUSrcA,
   output logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB,
   output logic                       memRead,
   output logic                       memWrite,
   output logic                       IorD,
   output logic                       memToReg,
   output logic                       trap,
   output logic [CNT_WIDTH-1:0]       instret
);

   localparam logic [OPCODE_WIDTH-1:0] OP_ALU_REG = OPCODE_WIDTH'(OPCODE_ALU_REG);
   localparam logic [OPCODE_WIDTH-1:0] OP_ALU_IMM = OPCODE_WIDTH'(OPCODE_ALU_IMM);
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD    = OPCODE_WIDTH'(OPCODE_LOAD);
   localparam logic [OPCODE_WIDTH-1:0] OP_STORE   = OPCODE_WIDTH'(OPCODE_STORE);
   localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH  = OPCODE_WIDTH'(OPCODE_BRANCH);

   state_t     state, state_next;
   logic [1:0] alu_src_b;
   logic       inc;

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_FETCH;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      PCWrite      = 1'b0;
      PCBranch     = 1'b0;
      IRWrite      = 1'b0;
      regFileWrite = 1'b0;
      ALUOverride  = 1'b0;
      ALUSrcA      = ALU_SRC_A_PC;
      alu_src_b    = ALU_SRC_B_REGOUT;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      IorD         = 1'b0;
      memToReg     = 1'b0;
      trap         = 1'b0;
      inc          = 1'b0;
      case (state)
         ST_FETCH: begin
            memRead     = 1'b1;
            ALUOverride = 1'b1;
            alu_src_b   = ALU_SRC_B_CONST4;
            IRWrite     = memReady;
            if (memReady)
               state_next = ST_DECODE;
         end
         ST_DECODE: begin
            PCWrite = 1'b1;
            if (opCode == OP_ALU_REG)
               state_next = ST_EXEC_R;
            else if (opCode == OP_ALU_IMM)
               state_next = ST_EXEC_I;
            else if (opCode == OP_LOAD || opCode == OP_STORE)
               state_next = ST_ADDR;
            else if (opCode == OP_BRANCH)
               state_next = ST_EXEC_B;
            else
`ifdef PHILV_ILLEGAL_TRAP_EN
               state_next = ST_TRAP;
`else
               state_next = ST_EXEC_R;
`endif
         end
         ST_EXEC_R: begin
            ALUSrcA    = ALU_SRC_A_REGOUT;
            alu_src_b  = ALU_SRC_B_REGOUT;
            state_next = ST_WRITEBACK;
         end
         ST_EXEC_I: begin
            ALUSrcA    = ALU_SRC_A_REGOUT;
            alu_src_b  = ALU_SRC_B_IMMED;
            state_next = ST_WRITEBACK;
         end
         ST_ADDR: begin
            ALUOverride = 1'b1;
            ALUSrcA     = ALU_SRC_A_REGOUT;
            alu_src_b   = ALU_SRC_B_IMMED;
            state_next  = (opCode == OP_LOAD) ? ST_MEM_LD : ST_MEM_ST;
         end
         ST_MEM_LD: begin
            memRead = 1'b1;
            IorD    = 1'b1;
            if (memReady)
               state_next = ST_WRITEBACK;
         end
         ST_MEM_ST: begin
            memWrite = 1'b1;
            IorD     = 1'b1;
            if (memReady) begin
               state_next = ST_FETCH;
               inc        = 1'b1;
            end
         end
         ST_EXEC_B: begin
            ALUSrcA    = ALU_SRC_A_REGOUT;
            alu_src_b  = ALU_SRC_B_REGOUT;
            PCBranch   = branchTaken;
            state_next = ST_FETCH;
            inc        = 1'b1;
         end
         ST_WRITEBACK: begin
            regFileWrite = 1'b1;
            memToReg     = (opCode == OP_LOAD);
            state_next   = ST_FETCH;
            inc          = 1'b1;
         end
`ifdef PHILV_ILLEGAL_TRAP_EN
         ST_TRAP: begin
            trap = 1'b1;
         end
`endif
         default: state_next = ST_FETCH;
      endcase
      // Requests and write enables must not escape while reset is held.
      if (rst) begin
         memRead      = 1'b0;
         memWrite     = 1'b0;
         PCWrite      = 1'b0;
         PCBranch     = 1'b0;
         IRWrite      = 1'b0;
         regFileWrite = 1'b0;
      end
   end

   assign ALUSrcB = ALU_SRC_B_WIDTH'(alu_src_b);

   retire_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_retire_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .count (instret)
   );

endmodule
